// File: rtl/upcounter_core.sv
// Decimal up-counter with prescaler and run/stop/clear command port.
// Feeds the four-digit display controller and the status LEDs.
module upcounter_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  output logic        cmd_ready,
  output logic [13:0] count,
  output logic        running,
  output logic        tick,
  output logic        wrap
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);
  localparam logic [13:0]   CNT_LAST = 14'(MAX_COUNT);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN_ST  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          rdy_q;

  logic acc;
  logic do_run;
  logic do_stop;
  logic do_clr;
  logic step_en;

  assign acc     = cmd_valid && rdy_q;
  assign do_run  = acc && (cmd == CMD_RUN);
  assign do_stop = acc && (cmd == CMD_STOP);
  assign do_clr  = acc && (cmd == CMD_CLR);

  // STOP takes effect before the prescaler decision
  assign step_en = (state_q == RUN_ST) && !do_clr && !do_stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STOPPED;
      ps_q    <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      do_run:  state_d = RUN_ST;
      do_stop: state_d = STOPPED;
      default: ;
    endcase
  end

  always_comb begin
    ps_d   = ps_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    unique case (1'b1)
      do_clr: begin
        ps_d  = '0;
        cnt_d = '0;
      end
      step_en: begin
        if (ps_q == PS_LAST) begin
          ps_d   = '0;
          tick_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    running   = (state_q == RUN_ST);
    cmd_ready = rdy_q;
    count     = cnt_q;
    tick      = tick_q;
    wrap      = wrap_q;
  end

endmodule

// File: doc/upcounter_core.md
# upcounter_core

Decimal up-counter (0..MAX_COUNT) that drives the 14-bit `data` input of the four-digit FND display controller. Accepts run, stop and clear commands from the SPI/I2C command slave over a valid/ready handshake. A parameterised prescaler sets the count rate. Also provides running-status, tick and wrap pulses for the LED and status logic.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 10: count rate in Hz. `DIV = CLK_FREQ / TICK_HZ` and must be ≥ 2.
- `MAX_COUNT`, default 9999: last value before wrap. Must be ≤ 9999 so the display never overflows.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset), sampled on rising `clk`.
- `cmd_valid`  input  1  command present.
- `cmd`  input  2  command code: 00 NOP, 01 RUN, 10 STOP, 11 CLEAR.
- `cmd_ready`  output  1  block can accept a command.
- `count`  output  14  current count in binary, 0..MAX_COUNT; goes to the display controller `data` input.
- `running`  output  1  1 in the RUN state.
- `tick`  output  1  one-cycle pulse on every count change caused by the prescaler.
- `wrap`  output  1  one-cycle pulse when the count rolls from MAX_COUNT to 0.

## Operation
- **States:** STOPPED and RUN. `running` = (state == RUN).
- **Command acceptance:** a command is accepted on an edge where `cmd_valid && cmd_ready`.
- **`cmd_ready`:** 0 while `reset` = 0; 1 on every other cycle. No backpressure beyond reset.
- **RUN command:** STOPPED → RUN. In RUN it has no effect; the prescaler is not restarted.
- **STOP command:** RUN → STOPPED. The prescaler and count are held, not cleared. The next RUN resumes mid-period.
- **CLEAR command:** `count` ← 0 and prescaler ← 0. The state is unchanged, so a running counter keeps running from 0.
- **NOP command:** accepted and ignored.
- **Prescaler:** a register of width `$clog2(DIV)`. It advances only in RUN and only on cycles where no CLEAR is accepted.
  - If prescaler == DIV-1: prescaler ← 0 and `count` steps.
  - Otherwise: prescaler ← prescaler + 1.
- **Count step:**
  - If `count` == MAX_COUNT: `count` ← 0 and `wrap` pulses.
  - Otherwise: `count` ← `count` + 1.
  - `tick` pulses on every step.
- **Priority on one edge:** reset > CLEAR > prescaler step.
  - A CLEAR on the same edge as a terminal prescaler value wins: `count` becomes 0, and `tick` and `wrap` stay 0.
- **Same-edge state change:** a STOP accepted on the edge where the prescaler is terminal suppresses the step. The state-transition edge uses the pre-edge state for the prescaler decision; STOP is treated as taking effect first, so there is no step.
- **Arithmetic:** `count` is never greater than MAX_COUNT. Any value above MAX_COUNT is unreachable, and an implementation must not rely on it.

## Timing
- **Reset values** (after any rising edge with `reset` = 0): state STOPPED, prescaler 0, `count` 0, `running` 0, `tick` 0, `wrap` 0, `cmd_ready` 0.
- **Reset mid-operation:** all registers return to their reset values on that edge. Any command presented in the same cycle is dropped.
- **Registered outputs:** all outputs are registered; none is combinational from inputs. The exception is `cmd_ready`, which is a register that is 1 from the first edge with `reset` = 1.
- **RUN latency:** RUN accepted at edge E0 → `running` = 1 after E0. The prescaler is 0 after E0, 1 after E1, …, DIV-1 after E(DIV-1). The first `count` increment is visible after E(DIV), i.e. DIV cycles after acceptance.
- **Steady state:** `tick` is high for exactly one cycle every DIV cycles, coincident with the new `count` value.
- **CLEAR latency:** `count` = 0 is visible one cycle after the accepting edge. The next step follows DIV cycles later if in RUN.
- **STOP latency:** `running` = 0 after the accepting edge. No `tick` occurs after that edge.
- **Wrap:** the cycle in which `count` shows 0 after MAX_COUNT has both `tick` and `wrap` = 1.

## Test plan
Bench parameters: `CLK_FREQ` = 100, `TICK_HZ` = 10, so DIV = 10.

1. **Reset:** hold `reset` = 0 for 3 cycles with `cmd_valid` = 1 and `cmd` = RUN → `count` = 0, `running` = 0, `cmd_ready` = 0. Release → `cmd_ready` = 1 next cycle, still STOPPED.
2. **Run:** RUN at edge E0 → `running` = 1. `count` becomes 1 exactly 10 cycles later with a 1-cycle `tick`. After 50 cycles `count` = 5, with 5 `tick` pulses and no `wrap`.
3. **Stop/resume:** RUN, wait 14 cycles (`count` = 1, prescaler 4), then STOP and idle 100 cycles → `count` stays 1 with no `tick`. RUN again → `count` = 2 after 6 cycles.
4. **Wrap:** `MAX_COUNT` = 12, run for 130 cycles → `count` goes 12 → 0 with `tick` = `wrap` = 1 in the same cycle. `wrap` is seen exactly once.
5. **Clear vs. tick:** running, issue CLEAR on the edge where the prescaler = 9 → `count` = 0, no `tick`/`wrap`, `running` still 1. The next increment is 10 cycles later.
6. **Reset mid-run:** while running at `count` = 7, drive `reset` = 0 for 1 cycle alongside a STOP command → all outputs at reset values, STOPPED. A RUN afterwards gives the first tick after 10 cycles.
